// File: rtl/vend_purchase_ctrl.sv
// ============================================================================
// Module   : vend_purchase_ctrl
// Purpose  : Purchase/payment controller for the vending machine. Latches the
//            requested channel and its price, checks stock, accumulates
//            coins, then dispenses with change or refunds on cancel. Owns
//            the stock counters of all 8 channels.
// Options  : VEND_TIMEOUT_EN - when defined, an idle PAY state refunds after
//            TIMEOUT_CYC cycles without a coin.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_purchase_ctrl #(
  parameter int unsigned PRICE_BASE  = 3,
  parameter int unsigned PRICE_STEP  = 2,
  parameter int unsigned STOCK_W     = 4,
  parameter int unsigned STOCK_INIT  = 4,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         buy_number,
  input  logic               buy_req,
  input  logic [1:0]         coin_in,
  input  logic               cancel,
  input  logic               restock,
  output logic [1:0]         state,
  output logic [2:0]         sel_channel,
  output logic [7:0]         price,
  output logic [7:0]         paid,
  output logic [7:0]         change,
  output logic               dispense,
  output logic               done,
  output logic               sold_out,
  output logic [STOCK_W-1:0] stock_out
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PAY      = 2'd1,
    S_DISPENSE = 2'd2,
    S_REFUND   = 2'd3
  } state_e;

  state_e             state_q;
  logic [2:0]         sel_q;
  logic [7:0]         price_q;
  logic [7:0]         paid_q;
  logic [7:0]         change_q;
  logic               sold_q;
  logic               disp_q;
  logic               done_q;
  logic [STOCK_W-1:0] stock_q [8];

  logic [7:0]         coin_val;
  logic [8:0]         paid_sum;
  logic [7:0]         paid_d;
  logic [7:0]         req_price;
  logic               avail;
  logic               timeout;

  // Coin decode and saturating running total of the payment
  always_comb begin
    coin_val = 8'd0;
    case (coin_in)
      2'b01:   coin_val = 8'd1;
      2'b10:   coin_val = 8'd5;
      2'b11:   coin_val = 8'd10;
      default: coin_val = 8'd0;
    endcase
    paid_sum = {1'b0, paid_q} + {1'b0, coin_val};
    paid_d   = paid_sum[8] ? 8'hFF : paid_sum[7:0];
  end

  assign req_price = 8'(PRICE_BASE) + 8'(buy_number) * 8'(PRICE_STEP);

  // A restock in the same cycle is applied before the request is judged
  assign avail     = restock ? (STOCK_INIT != 0) : (stock_q[buy_number] != '0);
  assign stock_out = stock_q[buy_number];

`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt_q;

  // Idle-payment counter: zero outside PAY and restarted by every coin
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (state_q != S_PAY || coin_in != 2'b00) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout = (state_q == S_PAY) && (coin_in == 2'b00) &&
                   (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign timeout        = 1'b0;
`endif

  // Transaction FSM with its datapath registers and stock counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      price_q  <= '0;
      paid_q   <= '0;
      change_q <= '0;
      sold_q   <= 1'b0;
      disp_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        stock_q[i] <= STOCK_W'(STOCK_INIT);
      end
    end else begin
      sold_q <= 1'b0;
      disp_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (restock) begin
            for (int i = 0; i < 8; i++) begin
              stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
          end
          if (buy_req) begin
            if (avail) begin
              state_q <= S_PAY;
              sel_q   <= buy_number;
              price_q <= req_price;
              paid_q  <= '0;
            end else begin
              sold_q  <= 1'b1;
            end
          end
        end
        S_PAY: begin
          // Coin of this cycle is always counted, even alongside cancel
          paid_q <= paid_d;
          if (cancel || timeout) begin
            state_q <= S_REFUND;
            done_q  <= 1'b1;
          end else if (paid_d >= price_q) begin
            state_q <= S_DISPENSE;
            disp_q  <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        S_DISPENSE: begin
          change_q       <= paid_q - price_q;
          stock_q[sel_q] <= stock_q[sel_q] - 1'b1;
          state_q        <= S_IDLE;
        end
        S_REFUND: begin
          change_q <= paid_q;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign sel_channel = sel_q;
  assign price       = price_q;
  assign paid        = paid_q;
  assign change      = change_q;
  assign dispense    = disp_q;
  assign done        = done_q;
  assign sold_out    = sold_q;

endmodule

`default_nettype wire

// File: tb/tb_vend_purchase_ctrl.sv
// ============================================================================
// Module   : tb_vend_purchase_ctrl
// Purpose  : Directed, table-driven bench for vend_purchase_ctrl. Built with
//            VEND_TIMEOUT_EN it also exercises the payment timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vend_purchase_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] buy_number;
  logic       buy_req;
  logic [1:0] coin_in;
  logic       cancel;
  logic       restock;
  logic [1:0] state;
  logic [2:0] sel_channel;
  logic [7:0] price;
  logic [7:0] paid;
  logic [7:0] change;
  logic       dispense;
  logic       done;
  logic       sold_out;
  logic [3:0] stock_out;

  int n_checks = 0;
  int n_fail   = 0;

  vend_purchase_ctrl #(
    .PRICE_BASE (3),
    .PRICE_STEP (2),
    .STOCK_W    (4),
    .STOCK_INIT (4),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .buy_number (buy_number),
    .buy_req    (buy_req),
    .coin_in    (coin_in),
    .cancel     (cancel),
    .restock    (restock),
    .state      (state),
    .sel_channel(sel_channel),
    .price      (price),
    .paid       (paid),
    .change     (change),
    .dispense   (dispense),
    .done       (done),
    .sold_out   (sold_out),
    .stock_out  (stock_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        req;
    logic [2:0]  num;
    logic [1:0]  coin;
    logic        cancel;
    logic        restock;
    logic [35:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Expected observation: {state, sel, price, paid, change, dispense, done, sold_out, stock_out}
  function automatic logic [35:0] E(int st, int sel, int pr, int pd, int ch,
                                    int d, int dn, int so, int stk);
    return {2'(st), 3'(sel), 8'(pr), 8'(pd), 8'(ch), 1'(d), 1'(dn), 1'(so), 4'(stk)};
  endfunction

  function automatic vec_t V(int r, int rq, int num, int coin, int can, int rs,
                             logic [35:0] exp);
    vec_t v;
    v.rst     = 1'(r);
    v.req     = 1'(rq);
    v.num     = 3'(num);
    v.coin    = 2'(coin);
    v.cancel  = 1'(can);
    v.restock = 1'(rs);
    v.exp     = exp;
    return v;
  endfunction

  function automatic logic [35:0] observe();
    return {state, sel_channel, price, paid, change, dispense, done, sold_out, stock_out};
  endfunction

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst        = v.rst;
    buy_req    = v.req;
    buy_number = v.num;
    coin_in    = v.coin;
    cancel     = v.cancel;
    restock    = v.restock;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; buy_req = 1'b0; buy_number = 3'd0;
    coin_in = 2'b00; cancel = 1'b0; restock = 1'b0;

    // Reset state
    tbl.push_back(V(1,0,0,0,0,0, E(0,0,0,0,0,0,0,0,4)));
    tbl.push_back(V(0,0,0,0,0,0, E(0,0,0,0,0,0,0,0,4)));
    // Channel 2 (price 7), coins 5+5 -> change 3, stock 3
    tbl.push_back(V(0,1,2,0,0,0, E(1,2,7,0,0,0,0,0,4)));
    tbl.push_back(V(0,0,2,2,0,0, E(1,2,7,5,0,0,0,0,4)));
    tbl.push_back(V(0,0,2,2,0,0, E(2,2,7,10,0,1,1,0,4)));
    tbl.push_back(V(0,0,2,0,0,0, E(0,2,7,10,3,0,0,0,3)));
    // Coin in IDLE is ignored
    tbl.push_back(V(0,0,2,3,0,0, E(0,2,7,10,3,0,0,0,3)));
    // Four purchases of channel 0 (price 3) with a 10 coin each
    for (int i = 0; i < 4; i++) begin
      tbl.push_back(V(0,1,0,0,0,0, E(1,0,3,0,(i==0)?3:7,0,0,0,4-i)));
      tbl.push_back(V(0,0,0,3,0,0, E(2,0,3,10,(i==0)?3:7,1,1,0,4-i)));
      tbl.push_back(V(0,0,0,0,0,0, E(0,0,3,10,7,0,0,0,3-i)));
    end
    // Fifth request: sold out pulse for one cycle, stay IDLE
    tbl.push_back(V(0,1,0,0,0,0, E(0,0,3,10,7,0,0,1,0)));
    tbl.push_back(V(0,0,0,0,0,0, E(0,0,3,10,7,0,0,0,0)));
    // Restock, then request accepted; exact payment with three 1-coins
    tbl.push_back(V(0,0,0,0,0,1, E(0,0,3,10,7,0,0,0,4)));
    tbl.push_back(V(0,1,0,0,0,0, E(1,0,3,0,7,0,0,0,4)));
    tbl.push_back(V(0,0,0,1,0,0, E(1,0,3,1,7,0,0,0,4)));
    tbl.push_back(V(0,0,0,1,0,0, E(1,0,3,2,7,0,0,0,4)));
    tbl.push_back(V(0,0,0,1,0,0, E(2,0,3,3,7,1,1,0,4)));
    tbl.push_back(V(0,0,0,0,0,0, E(0,0,3,3,0,0,0,0,3)));
    // Channel 7 (price 17): coin 10 (buy_req ignored in PAY), cancel -> refund 10
    tbl.push_back(V(0,1,7,0,0,0, E(1,7,17,0,0,0,0,0,4)));
    tbl.push_back(V(0,1,7,3,0,0, E(1,7,17,10,0,0,0,0,4)));
    tbl.push_back(V(0,0,7,0,1,0, E(3,7,17,10,0,0,1,0,4)));
    tbl.push_back(V(0,0,7,0,0,0, E(0,7,17,10,10,0,0,0,4)));
    // Channel 1 (price 5): completing coin and cancel together -> refund
    tbl.push_back(V(0,1,1,0,0,0, E(1,1,5,0,10,0,0,0,4)));
    tbl.push_back(V(0,0,1,2,1,0, E(3,1,5,5,10,0,1,0,4)));
    tbl.push_back(V(0,0,1,0,0,0, E(0,1,5,5,5,0,0,0,4)));
    // Reset in PAY with paid 6: everything back to reset values
    tbl.push_back(V(0,1,3,0,0,0, E(1,3,9,0,5,0,0,0,4)));
    tbl.push_back(V(0,0,3,2,0,0, E(1,3,9,5,5,0,0,0,4)));
    tbl.push_back(V(0,0,3,1,0,0, E(1,3,9,6,5,0,0,0,4)));
    tbl.push_back(V(1,0,2,0,0,0, E(0,0,0,0,0,0,0,0,4)));
    tbl.push_back(V(0,0,0,0,0,0, E(0,0,0,0,0,0,0,0,4)));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      check($sformatf("vec%0d", i), observe(), tbl[i].exp);
    end

    // Channel 7 purchase, one 1-coin, then silence
    drive(V(0,1,7,0,0,0, '0));
    check_bit("to_enter_pay", 8'(state), 8'd1);
    drive(V(0,0,7,1,0,0, '0));
    check_bit("to_paid_after_coin", paid, 8'd1);
`ifdef VEND_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      drive(V(0,0,7,0,0,0, '0));
      check_bit($sformatf("to_wait%0d_state", k), 8'(state), 8'd1);
    end
    drive(V(0,0,7,0,0,0, '0));
    check_bit("to_refund_state", 8'(state), 8'd3);
    check_bit("to_refund_done", 8'(done), 8'd1);
    drive(V(0,0,7,0,0,0, '0));
    check_bit("to_idle_state", 8'(state), 8'd0);
    check_bit("to_change", change, 8'd1);
`else
    for (int k = 1; k <= 40; k++) begin
      drive(V(0,0,7,0,0,0, '0));
      if (k % 10 == 0) check_bit($sformatf("nto_wait%0d_state", k), 8'(state), 8'd1);
    end
    check_bit("nto_paid_held", paid, 8'd1);
    drive(V(0,0,7,0,1,0, '0));
    check_bit("nto_refund_state", 8'(state), 8'd3);
    drive(V(0,0,7,0,0,0, '0));
    check_bit("nto_idle_state", 8'(state), 8'd0);
    check_bit("nto_change", change, 8'd1);
    check_bit("nto_stock7", 8'(stock_out), 8'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vend_purchase_ctrl.md
# vend_purchase_ctrl

Purchase/payment controller that sits directly downstream of the channel-inquiry stage of the vending machine. Accepts the confirmed channel number and purchase request, checks per-channel stock, accumulates inserted coins against a fixed per-channel price, then either dispenses and reports change or refunds on cancel. Owns the stock counters for all 8 channels.

## Interface
- PRICE_BASE, 3, price of channel 0 (yuan)
- PRICE_STEP, 2, price increment per channel number; price(n) = PRICE_BASE + n*PRICE_STEP
- STOCK_W, 4, stock counter width per channel
- STOCK_INIT, 4, stock loaded into every channel on reset and restock
- TIMEOUT_CYC, 1000, idle-payment timeout in cycles (used only with VEND_TIMEOUT_EN)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- buy_number  in  3  channel number from the inquiry stage
- buy_req  in  1  one-cycle purchase confirm; samples buy_number
- coin_in  in  2  coin this cycle: 00 none, 01 = 1, 10 = 5, 11 = 10 yuan
- cancel  in  1  abort payment, refund all paid
- restock  in  1  reload all stocks to STOCK_INIT (honoured in IDLE only)
- state  out  2  IDLE=0, PAY=1, DISPENSE=2, REFUND=3
- sel_channel  out  3  latched channel of current transaction
- price  out  8  latched price of current transaction
- paid  out  8  accumulated payment, saturates at 255
- change  out  8  money returned by last completed transaction
- dispense  out  1  high exactly during the DISPENSE cycle
- done  out  1  high during DISPENSE or REFUND cycle
- sold_out  out  1  one-cycle pulse: request rejected, stock of channel is 0
- stock_out  out  STOCK_W  current stock of buy_number (combinational read)

## Operation
- Reset: state=IDLE, sel_channel=0, price=0, paid=0, change=0, sold_out=0, all stocks=STOCK_INIT; dispense/done=0.
- IDLE: buy_req with stock[buy_number]>0 -> latch sel_channel, price; paid=0; go PAY. buy_req with stock 0 -> sold_out pulse next cycle, stay IDLE. Coins ignored. restock reloads stocks; restock and buy_req together: restock first, request evaluated against reloaded stock.
- PAY: coin value added to paid (saturating 8 bit). If updated paid >= price -> DISPENSE. cancel -> REFUND; coin in the same cycle as cancel is counted first. Coin completing payment and cancel together -> REFUND (cancel wins). buy_req, restock ignored.
- DISPENSE (1 cycle): dispense=1, done=1; change <= paid-price; stock[sel_channel] decremented at end of cycle; -> IDLE.
- REFUND (1 cycle): done=1; change <= paid; stock untouched; -> IDLE.
- paid, price, sel_channel, change hold their values in IDLE until the next accepted buy_req (change is not cleared on accept).
- Stock never underflows: PAY is entered only with stock>=1.

## Timing
- buy_req at edge t -> state=PAY from t+1; earliest coin counted at t+1.
- Coin completing payment sampled at edge t -> state=DISPENSE, paid updated at t+1; change valid at t+2, state=IDLE at t+2; next buy_req accepted when sampled at t+2.
- sold_out asserted in cycle after rejected buy_req, for one cycle.
- rst during any state returns to reset values on the next edge; transaction lost, no dispense or refund pulse.

## Configuration
- VEND_TIMEOUT_EN defined: in PAY, cycle counter cleared on entry and on every non-zero coin; reaching TIMEOUT_CYC-1 without a coin -> REFUND (identical to cancel). Without it: no counter, PAY waits indefinitely.

## Test plan
- Reset, buy_number=2 (price 7), buy_req, coins 5 then 5 -> paid=10, dispense one cycle, change=3, stock[2]=3.
- Four purchases of channel 0 (price 3) with one 10-coin each; fifth buy_req -> sold_out pulse, state stays IDLE; restock then buy_req -> PAY.
- Channel 7 (price 17), coins 10 then cancel -> REFUND, change=10, stock[7] unchanged, done one cycle.
- Channel 1 (price 5): coin 5 and cancel same cycle -> REFUND, change=5, no dispense.
- rst asserted mid-PAY with paid=6 -> next cycle state=IDLE, paid=0, stocks=STOCK_INIT; with VEND_TIMEOUT_EN and TIMEOUT_CYC=16, coin 1 then silence -> REFUND 16 cycles after coin, change=1.
